// File: rtl/fetch_return_mux.sv
// rtl/fetch_return_mux.sv - merges BIOS and instruction-memory return words into one registered stream
// Optional boot watchdog: define FETCH_RETURN_BOOT_WATCHDOG_EN.
module fetch_return_mux #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] NOP_WORD     = '0,
  parameter int                FLUSH_CYCLES = 2,
  parameter int                CNT_W        = 16,
  parameter int                WDOG_W       = 12
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] bios_data,
  input  logic [DATA_W-1:0] inst_data,
  input  logic              source,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              mode,
  output logic              pc_stall,
  output logic [CNT_W-1:0]  boot_count,
  output logic              bios_timeout
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_DRAIN = 2'b01,
    S_USER  = 2'b10
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t            r_state;
  logic [3:0]        r_drain;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_mode;
  logic              r_stall;
  logic [CNT_W-1:0]  r_boot_count;
  logic              w_go_drain;

`ifdef FETCH_RETURN_BOOT_WATCHDOG_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout;
  logic [WDOG_W-1:0] w_wdog_inc;
  logic              w_wdog_hit;

  assign w_wdog_inc = r_wdog + WDOG_W'(1);
  // Hit on the edge where the counter lands on all-ones; it then holds there.
  assign w_wdog_hit = (r_state == S_BOOT) && (&w_wdog_inc);
  assign w_go_drain = source || w_wdog_hit;

  always_ff @(posedge clock) begin
    if (rst || (r_state != S_BOOT && r_state != S_DRAIN && r_state != S_USER)) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_BOOT) begin
      if (!(&r_wdog)) r_wdog <= w_wdog_inc;
      if (w_wdog_hit) r_timeout <= 1'b1;
    end
  end

  assign bios_timeout = r_timeout;
`else
  assign w_go_drain   = source;
  assign bios_timeout = 1'b0 && (WDOG_W > 0);
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_drain      <= '0;
      r_instr      <= NOP_WORD;
      r_valid      <= 1'b0;
      r_mode       <= 1'b0;
      r_stall      <= 1'b0;
      r_boot_count <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_instr <= bios_data;
          r_valid <= 1'b1;
          r_mode  <= 1'b0;
          r_stall <= 1'b0;
          if (!(&r_boot_count)) r_boot_count <= r_boot_count + CNT_W'(1);
          if (w_go_drain) begin
            r_state <= S_DRAIN;
            r_drain <= FLUSH_INIT;
          end
        end
        S_DRAIN: begin
          r_instr <= NOP_WORD;
          r_valid <= 1'b0;
          r_mode  <= 1'b0;
          r_stall <= 1'b1;
          if (r_drain <= 4'd1) begin
            r_drain <= '0;
            r_state <= S_USER;
          end else begin
            r_drain <= r_drain - 4'd1;
          end
        end
        S_USER: begin
          r_instr <= inst_data;
          r_valid <= 1'b1;
          r_mode  <= 1'b1;
          r_stall <= 1'b0;
        end
        default: begin
          // Unused encoding: behave exactly like a reset.
          r_state      <= S_BOOT;
          r_drain      <= '0;
          r_instr      <= NOP_WORD;
          r_valid      <= 1'b0;
          r_mode       <= 1'b0;
          r_stall      <= 1'b0;
          r_boot_count <= '0;
        end
      endcase
    end
  end

  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign mode        = r_mode;
  assign pc_stall    = r_stall;
  assign boot_count  = r_boot_count;

endmodule

// File: tb/tb_fetch_return_mux.sv
// tb/tb_fetch_return_mux.sv - directed scoreboard bench for fetch_return_mux
module tb_fetch_return_mux;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        rst, src, rst1, src1;
  logic [31:0] bios, inst, bios1, inst1;
  logic [31:0] instr_out, instr_out1;
  logic        instr_valid, mode, pc_stall, bios_timeout;
  logic        instr_valid1, mode1, pc_stall1, bios_timeout1;
  logic [15:0] boot_count;
  logic [3:0]  boot_count1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        mode;
    logic        stall;
    logic [15:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clock = ~clock;

  fetch_return_mux u0 (
    .clock(clock), .rst(rst), .bios_data(bios), .inst_data(inst), .source(src),
    .instr_out(instr_out), .instr_valid(instr_valid), .mode(mode), .pc_stall(pc_stall),
    .boot_count(boot_count), .bios_timeout(bios_timeout)
  );

  fetch_return_mux #(.CNT_W(4), .WDOG_W(4)) u1 (
    .clock(clock), .rst(rst1), .bios_data(bios1), .inst_data(inst1), .source(src1),
    .instr_out(instr_out1), .instr_valid(instr_valid1), .mode(mode1), .pc_stall(pc_stall1),
    .boot_count(boot_count1), .bios_timeout(bios_timeout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] b, input logic [31:0] i, input logic s,
                      input logic [31:0] ei, input logic ev, input logic em, input logic es,
                      input logic [15:0] ec);
    exp_t e;
    rst = r; bios = b; inst = i; src = s;
    q0.push_back('{ei, ev, em, es, ec});
    @(posedge clock);
    #1;
    e = q0.pop_front();
    chk("instr_out", instr_out, e.instr);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, e.valid});
    chk("mode", {31'b0, mode}, {31'b0, e.mode});
    chk("pc_stall", {31'b0, pc_stall}, {31'b0, e.stall});
    chk("boot_count", {16'b0, boot_count}, {16'b0, e.cnt});
    chk("bios_timeout", {31'b0, bios_timeout}, 32'd0);
  endtask

  task automatic step1(input logic r, input logic [31:0] b, input logic [31:0] ei,
                       input logic ev, input logic [3:0] ec);
    exp_t e;
    rst1 = r; bios1 = b; inst1 = 32'hDEAD0000; src1 = 1'b0;
    q1.push_back('{ei, ev, 1'b0, 1'b0, {12'b0, ec}});
    @(posedge clock);
    #1;
    e = q1.pop_front();
    chk("u1_instr_out", instr_out1, e.instr);
    chk("u1_instr_valid", {31'b0, instr_valid1}, {31'b0, e.valid});
    chk("u1_mode", {31'b0, mode1}, 32'd0);
    chk("u1_pc_stall", {31'b0, pc_stall1}, 32'd0);
    chk("u1_boot_count", {28'b0, boot_count1}, {16'b0, e.cnt});
    chk("u1_bios_timeout", {31'b0, bios_timeout1}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; src = 1'b0; bios = '0; inst = '0;
    rst1 = 1'b1; src1 = 1'b0; bios1 = '0; inst1 = '0;

    // Reset, then first BIOS word
    step(1, 32'h1, 32'h2, 0, NOP, 0, 0, 0, 0);
    step(1, 32'h1, 32'h2, 0, NOP, 0, 0, 0, 0);
    step(0, 32'hA0000001, 32'h2, 0, 32'hA0000001, 1, 0, 0, 1);

    // Six BIOS words, drain of two bubbles, then user stream
    step(1, 32'h0, 32'h0, 0, NOP, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      step(0, 32'h10 + k, 32'hC0DE0000, 0, 32'h10 + k, 1, 0, 0, 16'(k + 1));
    step(0, 32'h15, 32'hC0DE0000, 1, 32'h15, 1, 0, 0, 6);
    step(0, 32'h16, 32'hC0DE0000, 0, NOP, 0, 0, 1, 6);
    step(0, 32'h17, 32'hC0DE0000, 1, NOP, 0, 0, 1, 6);
    step(0, 32'h18, 32'hC0DE0000, 0, 32'hC0DE0000, 1, 1, 0, 6);

    // source is ignored in USER
    step(0, 32'h19, 32'hC0DE0001, 1, 32'hC0DE0001, 1, 1, 0, 6);
    step(0, 32'h1A, 32'hC0DE0002, 0, 32'hC0DE0002, 1, 1, 0, 6);

    // Reset on the second drain cycle
    step(1, 32'h0, 32'h0, 0, NOP, 0, 0, 0, 0);
    step(0, 32'h20, 32'hBEEF, 1, 32'h20, 1, 0, 0, 1);
    step(0, 32'h21, 32'hBEEF, 0, NOP, 0, 0, 1, 1);
    step(1, 32'h22, 32'hBEEF, 0, NOP, 0, 0, 0, 0);
    step(0, 32'h30, 32'hBEEF, 0, 32'h30, 1, 0, 0, 1);

    // source held high from reset release
    step(1, 32'h0, 32'h0, 1, NOP, 0, 0, 0, 0);
    step(0, 32'h40, 32'h5000, 1, 32'h40, 1, 0, 0, 1);
    step(0, 32'h41, 32'h5001, 1, NOP, 0, 0, 1, 1);
    step(0, 32'h42, 32'h5002, 1, NOP, 0, 0, 1, 1);
    step(0, 32'h43, 32'h5003, 1, 32'h5003, 1, 1, 0, 1);
    step(0, 32'h44, 32'h5004, 1, 32'h5004, 1, 1, 0, 1);

    // Narrow counter saturates; watchdog compiled out so BOOT persists
    step1(1, 32'h0, NOP, 0, 4'd0);
    for (int k = 0; k < 20; k++)
      step1(0, 32'h900 + k, 32'h900 + k, 1, (k + 1 >= 15) ? 4'hF : 4'(k + 1));

    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q0.size() + q1.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
